sn_stream_gen: RTL

- Bipolar stochastic-number generator (SNG) bank: the transmit side for the up/down-counter accumulators in the MVM datapath.
- Latches N signed WIDTH-bit BN values and emits N parallel bipolar bitstreams of programmable length. Streams are framed by a start/valid/done handshake.
- Over one full period (2^WIDTH cycles), the number of ones per lane is exact, so a downstream up/down counter recovers 2·x with no random error.

---
 rtl/sng_pkg.sv | 32 +++
 rtl/sng_lfsr.sv | 29 ++
 rtl/sn_stream_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/sng_pkg.sv
// rtl/sng_pkg.sv - shared types, LFSR tap table and offset-binary helper for the SNG bank
package sng_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sng_state_t;

   // Tap masks for a shift-left Fibonacci LFSR; bit i set means stage i feeds back.
   localparam logic [7:0] TAPS_W4 = 8'h0C;  // x^4+x^3+1
   localparam logic [7:0] TAPS_W5 = 8'h14;  // x^5+x^3+1
   localparam logic [7:0] TAPS_W6 = 8'h30;  // x^6+x^5+1
   localparam logic [7:0] TAPS_W7 = 8'h60;  // x^7+x^6+1
   localparam logic [7:0] TAPS_W8 = 8'hB8;  // x^8+x^6+x^5+x^4+1

   function automatic logic [7:0] lfsr_taps(input int width);
      case (width)
         5:       return TAPS_W5;
         6:       return TAPS_W6;
         7:       return TAPS_W7;
         8:       return TAPS_W8;
         default: return TAPS_W4;
      endcase
   endfunction

   // Adding 2^(width-1) modulo 2^width is the same as flipping the sign bit.
   function automatic logic [7:0] offset_bin(input logic [7:0] x, input int width);
      return x ^ (8'h01 << (width - 1));
   endfunction

endpackage

// File: rtl/sng_lfsr.sv
// rtl/sng_lfsr.sv - de Bruijn (all-zero inserted) Fibonacci LFSR, period 2^WIDTH
module sng_lfsr #(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   output logic [WIDTH-1:0] state
);
   import sng_pkg::*;

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

   logic fb;

   // Inverting feedback when the low stages are all zero splices 0 between 100..0 and 00..01.
   assign fb = (^(state & TAPS)) ^ (state[WIDTH-2:0] == '0);

   always_ff @(posedge clk) begin
      if (rst || load) begin
         state <= SEED;
      end else if (en) begin
         state <= {state[WIDTH-2:0], fb};
      end
   end

endmodule

// File: rtl/sn_stream_gen.sv
// rtl/sn_stream_gen.sv - bipolar stochastic-number generator bank with start/valid/done framing
module sn_stream_gen #(
   parameter int               N_LANE = 4,
   parameter int               WIDTH  = 4,
   parameter int               LEN_W  = 8,
   parameter logic [WIDTH-1:0] SEED   = WIDTH'(4'b0001)
) (
   input  logic                             i_clk_sng,
   input  logic                             i_rst_sng,
   input  logic                             i_start_sng,
   input  logic                             i_stop_sng,
   input  logic [N_LANE-1:0][WIDTH-1:0]     i_x_sng,
   input  logic [LEN_W-1:0]                 i_len_sng,
   output logic                             o_busy_sng,
   output logic                             o_valid_sng,
   output logic [N_LANE-1:0]                o_sn_bit_sng,
   output logic                             o_done_sng
);
   import sng_pkg::*;

   sng_state_t                   state, state_nxt;
   logic [N_LANE-1:0][WIDTH-1:0] xo;
   logic [LEN_W-1:0]             len_q;
   logic [LEN_W-1:0]             cnt;
   logic [WIDTH-1:0]             r;
   logic                         start_ok;
   logic                         last;

   always_ff @(posedge i_clk_sng) begin
      if (i_rst_sng) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      start_ok    = 1'b0;
      o_busy_sng  = 1'b0;
      o_valid_sng = 1'b0;
      o_done_sng  = 1'b0;
      last        = (cnt == len_q);
      case (state)
         IDLE: begin
            if (i_start_sng) begin
               start_ok  = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            o_busy_sng  = 1'b1;
            o_valid_sng = 1'b1;
            if (last || i_stop_sng) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            o_busy_sng = 1'b1;
            o_done_sng = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // cnt counts bits already emitted, so the bit with cnt == len_q is the last one.
   always_ff @(posedge i_clk_sng) begin
      if (i_rst_sng) begin
         xo    <= '0;
         len_q <= '0;
         cnt   <= '0;
      end else if (start_ok) begin
         for (int k = 0; k < N_LANE; k++) begin
            xo[k] <= WIDTH'(offset_bin(8'(i_x_sng[k]), WIDTH));
         end
         len_q <= i_len_sng;
         cnt   <= '0;
      end else if (state == RUN) begin
         cnt <= cnt + LEN_W'(1);
      end
   end

   sng_lfsr #(
      .WIDTH (WIDTH),
      .SEED  (SEED)
   ) u_lfsr (
      .clk   (i_clk_sng),
      .rst   (i_rst_sng),
      .load  (start_ok),
      .en    (o_valid_sng),
      .state (r)
   );

   // XOR with the lane index permutes r per lane, so each lane still sees every value once.
   always_comb begin
      o_sn_bit_sng = '0;
      for (int k = 0; k < N_LANE; k++) begin
         o_sn_bit_sng[k] = o_valid_sng && (xo[k] > (r ^ WIDTH'(k)));
      end
   end

endmodule
